// File: rtl/jk_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK bank arbiter:
//   - JK operation encoding as {j,k}
//   - arbiter FSM state type
//   - jk_next(): next value of one JK cell for a given q/j/k
// -----------------------------------------------------------------------------
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } jk_state_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            JK_HOLD: return q;
            JK_RST:  return 1'b0;
            JK_SET:  return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter_if
// Bundle of requester-side and bank-status signals of the JK bank arbiter.
//   req_valid[i]  requester i presents an operation
//   req_ready[i]  requester i's operation is accepted this cycle (one-hot or 0)
//   req_op        {j,k} per requester, slice [2i+1:2i]
//   req_mask      per-requester bit mask, slice [WIDTH*i +: WIDTH]
//   req_lock[i]   keep ownership after this beat
//   q             bank contents
//   grant_valid   a beat was accepted on the previous edge
//   grant_id      index of the last accepted requester
//   locked        arbiter is in the locked state
//
// Handshake: a beat from requester i transfers on a rising clk edge where
// req_valid[i] && req_ready[i]. req_ready never depends on req_op, req_mask or
// req_lock; a requester may keep valid high for as long as it likes and its
// payload must stay stable until the beat transfers.
// -----------------------------------------------------------------------------
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_mask;
    logic [NREQ-1:0]       req_lock;
    logic [WIDTH-1:0]      q;
    logic                  grant_valid;
    logic [IDW-1:0]        grant_id;
    logic                  locked;

    // Requester side
    modport master (
        output req_valid, req_op, req_mask, req_lock,
        input  req_ready, q, grant_valid, grant_id, locked
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_mask, req_lock,
        output req_ready, q, grant_valid, grant_id, locked
    );
endinterface

// File: rtl/jk_bank_arbiter_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// One JK flip-flop with asynchronous active-low clear.
//   clk    rising-edge clock
//   clr_n  asynchronous active-low clear (q -> 0)
//   j, k   00 hold, 01 reset, 10 set, 11 toggle
//   q      flip-flop output
// -----------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q
);
    logic r_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, j, k);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Round-robin arbiter sharing one WIDTH-bit bank of JK cells among NREQ
// requesters, with an optional lock for atomic multi-beat sequences.
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   bus          jk_bank_arbiter_if.slave (requests, ready, bank status)
//   o_dbg_state  current arbiter FSM state
// -----------------------------------------------------------------------------
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              clr_n,
    jk_bank_arbiter_if.slave  bus,
    output jk_state_t         o_dbg_state
);

    jk_state_t        r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    logic             r_grant_valid;
    logic [IDW-1:0]   r_grant_id;
    logic             r_locked;

    logic             w_found;
    logic [IDW-1:0]   w_gid;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_ptr_next;
    int               w_idx;
    logic [NREQ-1:0]  w_ready;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_mask;
    logic             w_lock;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q;

    // Winner selection. Ready is gated by clr_n so nothing looks accepted
    // while the bank is held in reset.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        w_cand  = '0;
        if (clr_n) begin
            if (r_state == ST_IDLE) begin
                // Scan ptr, ptr+1, ... with wrap-around; first valid wins.
                for (int n = 0; n < NREQ; n++) begin
                    w_idx = int'(r_ptr) + n;
                    if (w_idx >= NREQ) begin
                        w_idx = w_idx - NREQ;
                    end
                    w_cand = IDW'(w_idx);
                    if (!w_found && bus.req_valid[w_cand]) begin
                        w_found = 1'b1;
                        w_gid   = w_cand;
                    end
                end
            end else if (bus.req_valid[r_owner]) begin
                w_found = 1'b1;
                w_gid   = r_owner;
            end
        end
    end

    // Ready one-hot plus the winner's payload, selected with constant indices.
    always_comb begin
        w_ready = '0;
        w_op    = JK_HOLD;
        w_mask  = '0;
        w_lock  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_found && (w_gid == IDW'(i))) begin
                w_ready[i] = 1'b1;
                w_op       = bus.req_op[2*i +: 2];
                w_mask     = bus.req_mask[WIDTH*i +: WIDTH];
                w_lock     = bus.req_lock[i];
            end
        end
    end

    // Masked-off bits and idle cycles drive j=k=0 so those cells hold.
    assign w_j = w_found ? (w_mask & {WIDTH{w_op[1]}}) : '0;
    assign w_k = w_found ? (w_mask & {WIDTH{w_op[0]}}) : '0;

    assign w_ptr_next = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

    // Arbiter FSM with registered status outputs. The pointer moves only on
    // beats that leave or stay in IDLE, so a lock holder never disturbs the
    // rotation of the others.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_locked      <= 1'b0;
        end else begin
            r_grant_valid <= w_found;
            if (w_found) begin
                r_grant_id <= w_gid;
                case (r_state)
                    ST_IDLE: begin
                        r_ptr <= w_ptr_next;
                        if (w_lock) begin
                            r_state  <= ST_LOCKED;
                            r_owner  <= w_gid;
                            r_locked <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_lock) begin
                            r_state  <= ST_IDLE;
                            r_locked <= 1'b0;
                            r_ptr    <= w_ptr_next;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        jk_cell u_cell (
            .clk   (clk),
            .clr_n (clr_n),
            .j     (w_j[b]),
            .k     (w_k[b]),
            .q     (w_q[b])
        );
    end

    assign bus.req_ready   = w_ready;
    assign bus.q           = w_q;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.locked      = r_locked;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;
    import jk_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int OW    = 1 + IDW + 1 + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();
    jk_state_t dbg_state;

    jk_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard queues ----------------
    logic [OW-1:0]   exp_q[$];
    int              exp_tag_q[$];
    logic [NREQ-1:0] rdy_q[$];
    int              rdy_tag_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_q;
    int               m_ptr;
    int               m_owner;
    bit               m_lk;
    bit               m_gv;
    int               m_gid;

    task automatic model_reset();
        m_q = '0; m_ptr = 0; m_owner = 0; m_lk = 0; m_gv = 0; m_gid = 0;
    endtask

    // Predicts this cycle's ready vector and the state after the coming edge,
    // then lets that edge happen. Returns at posedge+2.
    task automatic cycle();
        int win;
        int c;
        logic [NREQ-1:0]  rdy;
        logic [1:0]       op;
        logic [WIDTH-1:0] mk;
        bit               lk;
        win = -1;
        if (m_lk) begin
            if (bus.req_valid[m_owner]) win = m_owner;
        end else begin
            for (int n = 0; n < NREQ; n++) begin
                c = (m_ptr + n) % NREQ;
                if (win < 0 && bus.req_valid[c]) win = c;
            end
        end
        rdy = '0;
        if (win >= 0) rdy[win] = 1'b1;
        rdy_q.push_back(rdy);
        rdy_tag_q.push_back(cyc);

        m_gv = (win >= 0);
        if (win >= 0) begin
            op = bus.req_op[2*win +: 2];
            mk = bus.req_mask[WIDTH*win +: WIDTH];
            lk = bus.req_lock[win];
            for (int b = 0; b < WIDTH; b++) begin
                if (mk[b]) begin
                    if (op == JK_RST)      m_q[b] = 1'b0;
                    else if (op == JK_SET) m_q[b] = 1'b1;
                    else if (op == JK_TGL) m_q[b] = ~m_q[b];
                end
            end
            m_gid = win;
            if (!m_lk) begin
                m_ptr = (win + 1) % NREQ;
                if (lk) begin
                    m_lk    = 1;
                    m_owner = win;
                end
            end else if (!lk) begin
                m_lk  = 0;
                m_ptr = (win + 1) % NREQ;
            end
        end
        exp_q.push_back({m_gv, IDW'(m_gid), m_lk, m_q});
        exp_tag_q.push_back(cyc + 1);
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [OW-1:0]   e;
        logic [NREQ-1:0] r;
        int              t;
        while (rdy_tag_q.size() > 0 && rdy_tag_q[0] <= cyc) begin
            t = rdy_tag_q.pop_front();
            r = rdy_q.pop_front();
            if (t == cyc) check("req_ready", 32'(bus.req_ready), 32'(r));
            else          check("ready_entry_stale", t, cyc);
        end
        while (exp_tag_q.size() > 0 && exp_tag_q[0] <= cyc) begin
            t = exp_tag_q.pop_front();
            e = exp_q.pop_front();
            if (t == cyc) begin
                check("grant_valid", 32'(bus.grant_valid), 32'(e[OW-1]));
                check("grant_id", 32'(bus.grant_id), 32'(e[OW-2 -: IDW]));
                check("locked", 32'(bus.locked), 32'(e[WIDTH]));
                check("q", 32'(bus.q), 32'(e[WIDTH-1:0]));
            end else begin
                check("out_entry_stale", t, cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input bit v, input logic [1:0] op,
                           input logic [WIDTH-1:0] mk, input bit lk);
        bus.req_valid[i]           = v;
        bus.req_op[2*i +: 2]       = op;
        bus.req_mask[WIDTH*i +: WIDTH] = mk;
        bus.req_lock[i]            = lk;
    endtask

    task automatic idle_all();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_mask  = '0;
        bus.req_lock  = '0;
    endtask

    // Asserts clr_n mid-cycle with every requester valid, checks the
    // asynchronous clear, then releases mid-cycle with no requests pending.
    task automatic do_reset();
        @(negedge clk);
        #1;
        clr_n = 1'b0;
        bus.req_valid = '1;
        #1;
        check("rst_q", 32'(bus.q), 0);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_grant_valid", 32'(bus.grant_valid), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        model_reset();
        exp_q.delete(); exp_tag_q.delete(); rdy_q.delete(); rdy_tag_q.delete();
        repeat (2) @(posedge clk);
        #2;
        check("rst_hold_ready", 32'(bus.req_ready), 0);
        check("rst_hold_q", 32'(bus.q), 0);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_all();
        model_reset();
        do_reset();

        // Round robin: all valid, each sets its own bit.
        for (int i = 0; i < NREQ; i++) set_req(i, 1, JK_SET, WIDTH'(1 << i), 0);
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("rr_grant_valid", 32'(bus.grant_valid), 1);
            check("rr_grant_id", 32'(bus.grant_id), n % NREQ);
            if (n == 3) check("rr_q_after4", 32'(bus.q), 32'h0F);
        end

        // Masked ops.
        idle_all(); set_req(1, 1, JK_RST, 8'hFF, 0); cycle();
        idle_all(); set_req(1, 1, JK_SET, 8'hAA, 0); cycle();
        check("mask_q_AA", 32'(bus.q), 32'hAA);
        idle_all(); set_req(0, 1, JK_TGL, 8'h0F, 0); cycle();
        check("mask_tgl", 32'(bus.q), 32'hA5);
        idle_all(); set_req(1, 1, JK_RST, 8'hF0, 0); cycle();
        check("mask_rst", 32'(bus.q), 32'h05);
        idle_all(); set_req(1, 1, JK_HOLD, 8'hFF, 0); cycle();
        check("mask_hold", 32'(bus.q), 32'h05);

        // Lock: pointer now at 2, req2 wins and locks while req0/req1 wait.
        idle_all();
        set_req(0, 1, JK_HOLD, 8'h00, 0);
        set_req(1, 1, JK_HOLD, 8'h00, 0);
        set_req(2, 1, JK_SET, 8'h01, 1);
        cycle();
        check("lock_locked", 32'(bus.locked), 1);
        check("lock_gid", 32'(bus.grant_id), 2);
        check("lock_state", 32'(dbg_state), 32'(ST_LOCKED));
        set_req(2, 1, JK_TGL, 8'h80, 1);
        repeat (3) begin
            cycle();
            check("lock_owner_gid", 32'(bus.grant_id), 2);
            check("lock_owner_gv", 32'(bus.grant_valid), 1);
        end
        check("lock_q", 32'(bus.q), 32'h85);
        set_req(2, 0, JK_TGL, 8'h80, 1);
        repeat (3) begin
            cycle();
            check("lock_drop_gv", 32'(bus.grant_valid), 0);
            check("lock_drop_locked", 32'(bus.locked), 1);
        end
        set_req(2, 1, JK_RST, 8'h04, 0);
        cycle();
        check("unlock_locked", 32'(bus.locked), 0);
        check("unlock_q", 32'(bus.q), 32'h81);
        set_req(2, 0, JK_HOLD, 8'h00, 0);
        cycle();
        check("unlock_wrap_gid", 32'(bus.grant_id), 0);

        // Reset mid-lock.
        idle_all(); set_req(0, 1, JK_SET, 8'hFF, 1); cycle();
        check("prerst_locked", 32'(bus.locked), 1);
        check("prerst_q", 32'(bus.q), 32'hFF);
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, JK_SET, WIDTH'(1 << i), 0);
        cycle();
        check("postrst_gid", 32'(bus.grant_id), 0);
        check("postrst_q", 32'(bus.q), 32'h01);

        // Idle hold.
        idle_all(); set_req(1, 1, JK_RST, 8'hFF, 0); cycle();
        idle_all(); set_req(1, 1, JK_SET, 8'h3C, 0); cycle();
        idle_all();
        repeat (10) begin
            cycle();
            check("idle_q", 32'(bus.q), 32'h3C);
            check("idle_gv", 32'(bus.grant_valid), 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                        WIDTH'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
            end
            cycle();
        end
        idle_all();
        repeat (3) cycle();

        @(negedge clk);
        #1;
        check("drain_exp", exp_q.size(), 0);
        check("drain_rdy", rdy_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit bank of JK flip-flops among NREQ requesters. Each requester issues masked JK operations (hold/reset/set/toggle) through a valid/ready handshake. The arbiter grants one requester per cycle, drives the per-bit j/k inputs of the bank, and supports an optional multi-cycle lock so that one requester can perform atomic read-modify-write sequences. It sits between control agents and any shared status/flag register built from JK cells.

## Interface
- WIDTH, 8, number of JK cells in the bank (1..32).
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester index.
- clk  input  1  single clock; all state updates on its rising edge.
- clr_n  input  1  asynchronous, active-low reset; clears all state immediately.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_ready  output  NREQ  bit i: requester i's operation is accepted this cycle; at most one bit high.
- req_op  input  2*NREQ  slice [2i+1:2i] = {j,k} for requester i: 00 hold, 01 reset, 10 set, 11 toggle.
- req_mask  input  WIDTH*NREQ  slice i: bits to which the op applies; unmasked bits hold.
- req_lock  input  NREQ  bit i: keep ownership after this beat.
- q  output  WIDTH  current bank contents.
- grant_valid  output  1  registered; a beat was accepted on the previous edge.
- grant_id  output  IDW  registered index of the last accepted requester.
- locked  output  1  registered; FSM is in LOCKED.

## Operation
- FSM states: IDLE (open arbitration) and LOCKED (owner only).
- IDLE: req_ready is a one-hot of the first requester with req_valid=1, searched from index ptr upward with wrap-around (ptr, ptr+1, …, NREQ-1, 0, …). If no requester is valid, req_ready=0.
- On an accepted beat from requester g: ptr <= (g+1) mod NREQ. If req_lock[g]=1, go to LOCKED with owner <= g; otherwise stay in IDLE.
- LOCKED: req_ready[owner]=req_valid[owner]; all other ready bits are 0. If the owner drops valid, the FSM stays LOCKED. An owner beat with req_lock=0 returns the FSM to IDLE. ptr does not advance while LOCKED; it advances to owner+1 on the releasing beat.
- Bank update per bit b on an accepted beat: if mask[b]=1, then {j,k}=op; otherwise {j,k}=00. JK semantics: 00 q, 01 0, 10 1, 11 ~q.
- No accepted beat: all j=k=0, so the bank holds.
- req_op/req_mask/req_lock of non-granted requesters are ignored; a requester may hold valid indefinitely and will be served within NREQ grants (absent locks).

## Timing
- Reset (clr_n=0, async): q=0, ptr=0, state=IDLE, owner=0, grant_valid=0, grant_id=0, locked=0. req_ready=0 while clr_n=0.
- req_ready is combinational from req_valid, ptr and state; it has no dependency on req_op/mask/lock.
- Latency: an operation accepted in cycle n is visible on q in cycle n+1. grant_valid/grant_id/locked reflect the edge ending cycle n.
- Back-to-back: one beat per cycle sustained; the same requester may win consecutive cycles only if no other requester is valid, or if it is the lock owner.
- Reset asserted mid-lock: lock is dropped, q clears, and the beat in progress is discarded. After release, the first edge arbitrates from ptr=0.
- Toggle with all-ones mask inverts every bit in one cycle; a mask of all-zeros still counts as a beat (ptr advances, grant_valid=1).

## Structure
- Shared package jk_pkg: op encoding constants (JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11) and the FSM state typedef (ST_IDLE, ST_LOCKED).
- Sub-module jk_cell: one JK flip-flop with clk, async active-low clr_n, inputs j and k, output q. It is instantiated WIDTH times via generate. The arbiter contains only the pointer, the FSM and the j/k steering logic.

## Test plan
- Reset: hold clr_n=0 with all req_valid=1 -> q=0, req_ready=0, grant_valid=0. Release -> requester 0 granted first.
- Round-robin: all four valid, each with op=SET and mask=1<<i -> grants 0,1,2,3,0 on consecutive cycles; q=8'h0F after 4 beats.
- Masked ops: q=8'hAA, then req0 TGL mask 8'h0F -> q=8'hA5; then req1 RST mask 8'hF0 -> q=8'h05; then HOLD mask 8'hFF -> q=8'h05.
- Lock: req2 SET mask 8'h01 with lock=1 while req0/req1 are valid -> locked=1, only req2 is served; req2 drops valid for 3 cycles -> no grants; req2 beat with lock=0 -> next grant goes to req3 or wraps to req0.
- Reset mid-lock: clr_n pulsed low during LOCKED with q=8'hFF -> q=0 and locked=0 asynchronously; after release, arbitration restarts at requester 0.
- Idle hold: no valid for 10 cycles after q=8'h3C -> q stays 8'h3C, grant_valid=0 throughout.
